defuse_sequencer: RTL and testbench

// - Sequences defuse commands from mouse/button logic into the defuse-array generator.
// - Accepts one 1-based (x,y) request at a time and checks it against the level's grid bounds, mine array and defuse array.
// - Issues a single-cycle defuse pulse with held indices, then waits for the array to settle.
// - Returns a status code and tracks safe-field progress (all_clear).

---
 rtl/saper_pkg.sv | 58 +++++
 rtl/defuse_sequencer_if.sv | 26 ++
 rtl/defuse_cell_lookup.sv | 57 +++++
 rtl/defuse_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_defuse_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/saper_pkg.sv
// Shared types, sizes and helpers for the minesweeper defuse path.
package saper_pkg;

   typedef enum logic [1:0] {
      LVL_NONE   = 2'b00,
      LVL_EASY   = 2'b01,
      LVL_MEDIUM = 2'b10,
      LVL_HARD   = 2'b11
   } level_t;

   typedef enum logic [1:0] {
      RESP_OK    = 2'b00,
      RESP_DUP   = 2'b01,
      RESP_MINE  = 2'b10,
      RESP_RANGE = 2'b11
   } resp_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_CHECK  = 2'b01,
      ST_ISSUE  = 2'b10,
      ST_SETTLE = 2'b11
   } state_t;

   localparam int unsigned COORD_W  = 5;
   localparam int unsigned CNT_W    = 9;
   localparam int unsigned N_EASY   = 8;
   localparam int unsigned N_MEDIUM = 10;
   localparam int unsigned N_HARD   = 16;

   localparam int unsigned MINES_EASY_DEF   = 8;
   localparam int unsigned MINES_MEDIUM_DEF = 15;
   localparam int unsigned MINES_HARD_DEF   = 40;

   // Grid edge length for a level; 0 for "no level" so every coordinate fails the range check.
   function automatic logic [COORD_W-1:0] grid_n(input level_t lvl);
      case (lvl)
         LVL_EASY:   grid_n = COORD_W'(N_EASY);
         LVL_MEDIUM: grid_n = COORD_W'(N_MEDIUM);
         LVL_HARD:   grid_n = COORD_W'(N_HARD);
         default:    grid_n = '0;
      endcase
   endfunction

   // Number of safe fields (cells without a mine) for a level and its mine counts.
   function automatic logic [CNT_W-1:0] safe_fields(input level_t lvl,
                                                    input int unsigned mines_easy,
                                                    input int unsigned mines_medium,
                                                    input int unsigned mines_hard);
      case (lvl)
         LVL_EASY:   safe_fields = CNT_W'(N_EASY * N_EASY - mines_easy);
         LVL_MEDIUM: safe_fields = CNT_W'(N_MEDIUM * N_MEDIUM - mines_medium);
         LVL_HARD:   safe_fields = CNT_W'(N_HARD * N_HARD - mines_hard);
         default:    safe_fields = '0;
      endcase
   endfunction

endpackage

// File: rtl/defuse_sequencer_if.sv
// Request/response and defuse-command bus between the input logic, the sequencer
// and the defuse-array generator.
interface defuse_sequencer_if;
   import saper_pkg::*;

   logic               req_valid;
   logic               req_ready;
   logic [COORD_W-1:0] req_x;
   logic [COORD_W-1:0] req_y;
   logic               defuse;
   logic [COORD_W-1:0] defuse_ind_x;
   logic [COORD_W-1:0] defuse_ind_y;
   logic               resp_valid;
   resp_t              resp;

   modport master (
      output req_valid, req_x, req_y,
      input  req_ready, defuse, defuse_ind_x, defuse_ind_y, resp_valid, resp
   );

   modport slave (
      input  req_valid, req_x, req_y,
      output req_ready, defuse, defuse_ind_x, defuse_ind_y, resp_valid, resp
   );

endinterface

// File: rtl/defuse_cell_lookup.sv
// Combinational cell lookup: selects the level's mine/defused arrays at [y-1][x-1].
module defuse_cell_lookup
   import saper_pkg::*;
(
   input  level_t               level,
   input  logic                 in_range,
   input  logic [COORD_W-1:0]   x,
   input  logic [COORD_W-1:0]   y,
   input  logic [7:0][7:0]      mine_arr_easy,
   input  logic [9:0][9:0]      mine_arr_medium,
   input  logic [15:0][15:0]    mine_arr_hard,
   input  logic [7:0][7:0]      defused_easy,
   input  logic [9:0][9:0]      defused_medium,
   input  logic [15:0][15:0]    defused_hard,
   output logic                 is_mine,
   output logic                 is_defused
);

   logic [3:0] xi;
   logic [3:0] yi;

   // Zero-based indices only once the range check has passed, so x=0/y=0 never wraps.
   always_comb begin
      xi = '0;
      yi = '0;
      if (in_range) begin
         xi = 4'(x - 5'd1);
         yi = 4'(y - 5'd1);
      end
   end

   always_comb begin
      is_mine    = 1'b0;
      is_defused = 1'b0;
      if (in_range) begin
         case (level)
            LVL_EASY: begin
               is_mine    = mine_arr_easy[yi[2:0]][xi[2:0]];
               is_defused = defused_easy[yi[2:0]][xi[2:0]];
            end
            LVL_MEDIUM: begin
               is_mine    = mine_arr_medium[yi][xi];
               is_defused = defused_medium[yi][xi];
            end
            LVL_HARD: begin
               is_mine    = mine_arr_hard[yi][xi];
               is_defused = defused_hard[yi][xi];
            end
            default: begin
               is_mine    = 1'b0;
               is_defused = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/defuse_sequencer.sv
// Defuse request sequencer: range/mine/duplicate checks, one-cycle defuse issue, settle wait, progress count.
// Optional DEFUSE_SEQ_LOCK_EN: a MINE response or all_clear locks out requests until restart.
module defuse_sequencer
   import saper_pkg::*;
#(
   parameter int unsigned SETTLE_CYC   = 2,
   parameter int unsigned MINES_EASY   = MINES_EASY_DEF,
   parameter int unsigned MINES_MEDIUM = MINES_MEDIUM_DEF,
   parameter int unsigned MINES_HARD   = MINES_HARD_DEF
)(
   input  logic                 clk,
   input  logic                 rst,
   input  level_t               level,
   input  logic                 restart,
   defuse_sequencer_if.slave    bus,
   input  logic [7:0][7:0]      mine_arr_easy,
   input  logic [9:0][9:0]      mine_arr_medium,
   input  logic [15:0][15:0]    mine_arr_hard,
   input  logic [7:0][7:0]      defused_easy,
   input  logic [9:0][9:0]      defused_medium,
   input  logic [15:0][15:0]    defused_hard,
   output logic [CNT_W-1:0]     defused_cnt,
   output logic                 all_clear
);

`ifdef DEFUSE_SEQ_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   localparam int unsigned SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0]    CNT_MAX     = '1;

   state_t               state;
   level_t               cap_level;
   logic [COORD_W-1:0]   cap_x;
   logic [COORD_W-1:0]   cap_y;
   logic [SETTLE_W-1:0]  settle_cnt;
   logic                 lock;

   logic                 ready_q;
   logic                 defuse_q;
   logic [COORD_W-1:0]   ind_x_q;
   logic [COORD_W-1:0]   ind_y_q;
   logic                 resp_valid_q;
   resp_t                resp_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 all_clear_q;

   logic [COORD_W-1:0]   n_c;
   logic                 in_range_c;
   logic                 is_mine_c;
   logic                 is_defused_c;
   logic [CNT_W-1:0]     cnt_inc_c;
   logic [CNT_W-1:0]     safe_c;
   logic                 hit_clear_c;
   logic                 mine_lock_c;
   logic                 clear_lock_c;

   // Range check on the captured request; all compares are 5-bit against the grid size.
   always_comb begin
      n_c        = grid_n(cap_level);
      in_range_c = (cap_level != LVL_NONE) && (cap_x != '0) && (cap_y != '0)
                   && (cap_x <= n_c) && (cap_y <= n_c);
   end

   defuse_cell_lookup u_lookup (
      .level           (cap_level),
      .in_range        (in_range_c),
      .x               (cap_x),
      .y               (cap_y),
      .mine_arr_easy   (mine_arr_easy),
      .mine_arr_medium (mine_arr_medium),
      .mine_arr_hard   (mine_arr_hard),
      .defused_easy    (defused_easy),
      .defused_medium  (defused_medium),
      .defused_hard    (defused_hard),
      .is_mine         (is_mine_c),
      .is_defused      (is_defused_c)
   );

   // Progress bookkeeping for an OK issue: saturating increment and the all-clear target.
   always_comb begin
      cnt_inc_c    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      safe_c       = safe_fields(cap_level, MINES_EASY, MINES_MEDIUM, MINES_HARD);
      hit_clear_c  = (cnt_inc_c == safe_c);
      mine_lock_c  = LOCK_EN && in_range_c && is_mine_c;
      clear_lock_c = LOCK_EN && hit_clear_c;
   end

   // Sequencer FSM with registered outputs; restart outranks everything but rst.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ST_IDLE;
         cap_level    <= LVL_NONE;
         cap_x        <= '0;
         cap_y        <= '0;
         settle_cnt   <= '0;
         lock         <= 1'b0;
         ready_q      <= 1'b1;
         defuse_q     <= 1'b0;
         ind_x_q      <= '0;
         ind_y_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_q       <= RESP_OK;
         cnt_q        <= '0;
         all_clear_q  <= 1'b0;
      end else if (restart) begin
         state        <= ST_IDLE;
         settle_cnt   <= '0;
         lock         <= 1'b0;
         ready_q      <= 1'b1;
         defuse_q     <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_q       <= RESP_OK;
         cnt_q        <= '0;
         all_clear_q  <= 1'b0;
      end else begin
         defuse_q     <= 1'b0;
         resp_valid_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (level != cap_level) begin
                  cnt_q       <= '0;
                  all_clear_q <= 1'b0;
               end
               if (bus.req_valid && ready_q) begin
                  cap_x     <= bus.req_x;
                  cap_y     <= bus.req_y;
                  cap_level <= level;
                  ready_q   <= 1'b0;
                  state     <= ST_CHECK;
               end
            end

            ST_CHECK: begin
               if (!in_range_c || is_mine_c || is_defused_c) begin
                  resp_valid_q <= 1'b1;
                  if (!in_range_c)
                     resp_q <= RESP_RANGE;
                  else if (is_mine_c)
                     resp_q <= RESP_MINE;
                  else
                     resp_q <= RESP_DUP;
                  lock    <= lock || mine_lock_c;
                  ready_q <= !(lock || mine_lock_c);
                  state   <= ST_IDLE;
               end else begin
                  defuse_q     <= 1'b1;
                  ind_x_q      <= cap_x;
                  ind_y_q      <= cap_y;
                  resp_valid_q <= 1'b1;
                  resp_q       <= RESP_OK;
                  cnt_q        <= cnt_inc_c;
                  all_clear_q  <= hit_clear_c;
                  lock         <= lock || clear_lock_c;
                  state        <= ST_ISSUE;
               end
            end

            ST_ISSUE: begin
               settle_cnt <= '0;
               state      <= ST_SETTLE;
            end

            ST_SETTLE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  ready_q <= !lock;
                  state   <= ST_IDLE;
               end else begin
                  settle_cnt <= settle_cnt + SETTLE_W'(1);
               end
            end

            default: begin
               ready_q <= !lock;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready    = ready_q;
   assign bus.defuse       = defuse_q;
   assign bus.defuse_ind_x = ind_x_q;
   assign bus.defuse_ind_y = ind_y_q;
   assign bus.resp_valid   = resp_valid_q;
   assign bus.resp         = resp_q;
   assign defused_cnt      = cnt_q;
   assign all_clear        = all_clear_q;

endmodule

// File: tb/tb_defuse_sequencer.sv
// Directed bench for defuse_sequencer: vector table plus multi-cycle corner sequences.
module tb_defuse_sequencer;
   import saper_pkg::*;

   localparam int unsigned SETTLE = 2;

   logic clk;
   logic rst;
   level_t level;
   logic restart;
   logic [7:0][7:0]   mine_easy, def_easy;
   logic [9:0][9:0]   mine_med, def_med;
   logic [15:0][15:0] mine_hard, def_hard;
   logic [8:0] cnt;
   logic all_clear;

   int n_vec = 0;
   int n_bad = 0;

   defuse_sequencer_if bus ();

   defuse_sequencer #(.SETTLE_CYC(SETTLE)) dut (
      .clk             (clk),
      .rst             (rst),
      .level           (level),
      .restart         (restart),
      .bus             (bus),
      .mine_arr_easy   (mine_easy),
      .mine_arr_medium (mine_med),
      .mine_arr_hard   (mine_hard),
      .defused_easy    (def_easy),
      .defused_medium  (def_med),
      .defused_hard    (def_hard),
      .defused_cnt     (cnt),
      .all_clear       (all_clear)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      level_t     lvl;
      logic [4:0] x;
      logic [4:0] y;
      resp_t      resp;
      int         pulses;
      int         cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Called at a negedge; returns once req_ready is high (bounded).
   task automatic wait_ready();
      int g = 0;
      while (bus.req_ready !== 1'b1 && g < 40) begin
         @(negedge clk);
         g++;
      end
      check("ready_wait_timeout", 32'(g >= 40), 0);
   endtask

   // One full request: set level, wait for ready, handshake, observe 8 cycles afterwards.
   task automatic do_req(input level_t lv, input logic [4:0] x, input logic [4:0] y,
                         output resp_t r, output int nresp, output int npulse,
                         output int ix, output int iy, output int c);
      @(negedge clk);
      level = lv;
      repeat (2) @(negedge clk);
      wait_ready();
      bus.req_valid = 1'b1;
      bus.req_x     = x;
      bus.req_y     = y;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.req_x     = '0;
      bus.req_y     = '0;
      r = RESP_OK; nresp = 0; npulse = 0; ix = 0; iy = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.defuse) begin
            npulse++;
            ix = 32'(bus.defuse_ind_x);
            iy = 32'(bus.defuse_ind_y);
         end
         if (bus.resp_valid) begin
            nresp++;
            r = bus.resp;
         end
      end
      c = 32'(cnt);
   endtask

   task automatic pulse_restart();
      @(negedge clk);
      restart = 1'b1;
      @(posedge clk);
      #1;
      restart = 1'b0;
   endtask

   initial begin
      resp_t r;
      int nresp, npulse, ix, iy, c, k, zeros, pulses, resps;
      logic d2, rv2;
      logic [1:0] rs2;
      logic [4:0] ix2, iy2;
      logic [8:0] c2;
      logic rd5;

      rst = 1'b0; restart = 1'b0; level = LVL_NONE;
      bus.req_valid = 1'b0; bus.req_x = '0; bus.req_y = '0;
      mine_easy = '0; mine_med = '0; mine_hard = '0;
      def_easy = '0; def_med = '0; def_hard = '0;
      for (int i = 0; i < 8; i++) mine_easy[i][i] = 1'b1;
      mine_med[0][0]  = 1'b1;
      mine_hard[5][6] = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_defuse", 32'(bus.defuse), 0);
      check("rst_resp_valid", 32'(bus.resp_valid), 0);
      check("rst_resp", 32'(bus.resp), 0);
      check("rst_cnt", 32'(cnt), 0);
      check("rst_all_clear", 32'(all_clear), 0);
      rst = 1'b1;
      @(negedge clk);
      check("rst_ready_after_release", 32'(bus.req_ready), 1);

      // First OK request: exact cycle timing of pulse, response and ready gap
      level = LVL_EASY;
      repeat (2) @(negedge clk);
      bus.req_valid = 1'b1; bus.req_x = 5'd3; bus.req_y = 5'd4;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0; bus.req_x = 5'd31; bus.req_y = 5'd0;
      pulses = 0; zeros = 0;
      d2 = 0; rv2 = 0; rs2 = '0; ix2 = '0; iy2 = '0; c2 = '0; rd5 = 0;
      for (int kk = 1; kk <= 6; kk++) begin
         @(negedge clk);
         if (bus.defuse) pulses++;
         if (kk <= 2 + SETTLE && !bus.req_ready) zeros++;
         if (kk == 2) begin
            d2 = bus.defuse; rv2 = bus.resp_valid; rs2 = bus.resp;
            ix2 = bus.defuse_ind_x; iy2 = bus.defuse_ind_y; c2 = cnt;
         end
         if (kk == 3 + SETTLE) rd5 = bus.req_ready;
      end
      check("ok_defuse_at_t2", 32'(d2), 1);
      check("ok_pulse_count", 32'(pulses), 1);
      check("ok_resp_valid_at_t2", 32'(rv2), 1);
      check("ok_resp_code", 32'(rs2), 32'(RESP_OK));
      check("ok_ind_x", 32'(ix2), 3);
      check("ok_ind_y", 32'(iy2), 4);
      check("ok_cnt", 32'(c2), 1);
      check("ok_ready_low_cycles", 32'(zeros), 2 + SETTLE);
      check("ok_ready_back", 32'(rd5), 1);
      def_easy[3][2] = 1'b1;

      // Vector table: {level, x, y, resp, defuse pulses, cnt afterwards}
      vecs.push_back('{LVL_MEDIUM, 5'd11, 5'd2,  RESP_RANGE, 0, 0});
      vecs.push_back('{LVL_MEDIUM, 5'd0,  5'd5,  RESP_RANGE, 0, 0});
      vecs.push_back('{LVL_MEDIUM, 5'd10, 5'd0,  RESP_RANGE, 0, 0});
      vecs.push_back('{LVL_MEDIUM, 5'd10, 5'd10, RESP_OK,    1, 1});
      vecs.push_back('{LVL_MEDIUM, 5'd10, 5'd10, RESP_DUP,   0, 1});
      vecs.push_back('{LVL_MEDIUM, 5'd16, 5'd3,  RESP_RANGE, 0, 1});
      vecs.push_back('{LVL_MEDIUM, 5'd2,  5'd3,  RESP_OK,    1, 2});
      vecs.push_back('{LVL_EASY,   5'd3,  5'd4,  RESP_DUP,   0, 0});
      vecs.push_back('{LVL_EASY,   5'd9,  5'd1,  RESP_RANGE, 0, 0});
      vecs.push_back('{LVL_EASY,   5'd8,  5'd7,  RESP_OK,    1, 1});
      vecs.push_back('{LVL_NONE,   5'd1,  5'd1,  RESP_RANGE, 0, 0});
      vecs.push_back('{LVL_HARD,   5'd16, 5'd16, RESP_OK,    1, 1});
      vecs.push_back('{LVL_HARD,   5'd1,  5'd16, RESP_OK,    1, 2});
      vecs.push_back('{LVL_HARD,   5'd7,  5'd6,  RESP_MINE,  0, 2});

      foreach (vecs[i]) begin
         do_req(vecs[i].lvl, vecs[i].x, vecs[i].y, r, nresp, npulse, ix, iy, c);
         check($sformatf("v%0d_resp_strobes", i), 32'(nresp), 1);
         check($sformatf("v%0d_resp", i), 32'(r), 32'(vecs[i].resp));
         check($sformatf("v%0d_pulses", i), 32'(npulse), 32'(vecs[i].pulses));
         check($sformatf("v%0d_cnt", i), 32'(c), 32'(vecs[i].cnt));
         if (vecs[i].pulses == 1) begin
            check($sformatf("v%0d_ind_x", i), 32'(ix), 32'(vecs[i].x));
            check($sformatf("v%0d_ind_y", i), 32'(iy), 32'(vecs[i].y));
            case (vecs[i].lvl)
               LVL_EASY:   def_easy[vecs[i].y - 1][vecs[i].x - 1] = 1'b1;
               LVL_MEDIUM: def_med[vecs[i].y - 1][vecs[i].x - 1]  = 1'b1;
               LVL_HARD:   def_hard[vecs[i].y - 1][vecs[i].x - 1] = 1'b1;
               default: ;
            endcase
         end
      end

      // After MINE: lock holds ready low only when the lock feature is built in
      repeat (6) @(negedge clk);
`ifdef DEFUSE_SEQ_LOCK_EN
      check("mine_lock_ready", 32'(bus.req_ready), 0);
`else
      check("mine_nolock_ready", 32'(bus.req_ready), 1);
`endif
      pulse_restart();
      @(negedge clk);
      check("restart_ready", 32'(bus.req_ready), 1);
      check("restart_cnt", 32'(cnt), 0);
      check("restart_resp", 32'(bus.resp), 0);

      // Easy grid: all 56 safe cells, all_clear only after the last
      def_easy = '0;
      k = 0;
      for (int y = 1; y <= 8; y++) begin
         for (int x = 1; x <= 8; x++) begin
            if (x != y) begin
               k++;
               do_req(LVL_EASY, 5'(x), 5'(y), r, nresp, npulse, ix, iy, c);
               check($sformatf("clr%0d_resp", k), 32'(r), 32'(RESP_OK));
               check($sformatf("clr%0d_cnt", k), 32'(c), 32'(k));
               check($sformatf("clr%0d_all_clear", k), 32'(all_clear), 32'(k == 56));
               def_easy[y-1][x-1] = 1'b1;
            end
         end
      end
      @(negedge clk);
      level = LVL_MEDIUM;
      repeat (2) @(negedge clk);
      check("lvl_change_cnt", 32'(cnt), 0);
      check("lvl_change_all_clear", 32'(all_clear), 0);

      // rst asserted during SETTLE
      pulse_restart();
      @(negedge clk);
      level = LVL_EASY;
      def_easy = '0;
      repeat (2) @(negedge clk);
      wait_ready();
      bus.req_valid = 1'b1; bus.req_x = 5'd2; bus.req_y = 5'd1;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("rstseq_defuse_before", 32'(bus.defuse), 1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rstseq_defuse", 32'(bus.defuse), 0);
      check("rstseq_resp_valid", 32'(bus.resp_valid), 0);
      check("rstseq_cnt", 32'(cnt), 0);
      check("rstseq_all_clear", 32'(all_clear), 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rstseq_ready", 32'(bus.req_ready), 1);
      do_req(LVL_EASY, 5'd2, 5'd1, r, nresp, npulse, ix, iy, c);
      check("rstseq_next_resp", 32'(r), 32'(RESP_OK));
      check("rstseq_next_pulses", 32'(npulse), 1);
      check("rstseq_next_cnt", 32'(c), 1);
      def_easy[0][1] = 1'b1;

      // restart during CHECK aborts the request
      @(negedge clk);
      wait_ready();
      bus.req_valid = 1'b1; bus.req_x = 5'd4; bus.req_y = 5'd1;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      restart = 1'b1;
      @(posedge clk);
      #1;
      restart = 1'b0;
      pulses = 0; resps = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.defuse) pulses++;
         if (bus.resp_valid) resps++;
      end
      check("abort_pulses", 32'(pulses), 0);
      check("abort_resps", 32'(resps), 0);
      check("abort_cnt", 32'(cnt), 0);
      check("abort_ready", 32'(bus.req_ready), 1);
      do_req(LVL_EASY, 5'd4, 5'd1, r, nresp, npulse, ix, iy, c);
      check("abort_next_resp", 32'(r), 32'(RESP_OK));
      check("abort_next_cnt", 32'(c), 1);

      // restart coincident with req_valid: request ignored
      @(negedge clk);
      wait_ready();
      bus.req_valid = 1'b1; bus.req_x = 5'd5; bus.req_y = 5'd1; restart = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0; restart = 1'b0;
      pulses = 0;
      @(negedge clk);
      check("coinc_ready", 32'(bus.req_ready), 1);
      check("coinc_cnt", 32'(cnt), 0);
      repeat (5) begin
         @(negedge clk);
         if (bus.defuse || bus.resp_valid) pulses++;
      end
      check("coinc_no_activity", 32'(pulses), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
